// File: rtl/acc_seq_nbit.sv
// Purpose : double-width {high,low} accumulator with command handshake and bit-serial shift/rotate.
// Latency : load/clear/NOP and zero-length shifts update on acceptance, done next cycle; k-bit shift takes k busy cycles, then done.
// Backpressure: cmd_ready is low while a shift is sequencing; cmd_valid in that window is dropped, not queued.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   high_clr                     idle-only synchronous clear of the high half
//   cmd_valid/cmd_ready          command handshake; cmd_op, cmd_amt, fill_value are captured on acceptance
//   in_select, bus_data, alu_data  LOAD_HIGH source (1 = bus, 0 = ALU)
//   rd_en                        gates the tristate bus drivers high_data2bus / low_data2bus
//   acc_high_data2alu/acc_low_data2alu  registers, always driven
//   busy, done                   shift in progress / one-cycle completion pulse
module acc_seq_nbit #(
    parameter int W    = 8,
    parameter int SH_W = 4   // largest shift, 2**SH_W-1, must not exceed 2*W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            high_clr,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [SH_W-1:0] cmd_amt,
    input  logic            fill_value,
    input  logic            in_select,
    input  logic [W-1:0]    bus_data,
    input  logic [W-1:0]    alu_data,
    input  logic            rd_en,
    output logic [W-1:0]    high_data2bus,
    output logic [W-1:0]    low_data2bus,
    output logic [W-1:0]    acc_high_data2alu,
    output logic [W-1:0]    acc_low_data2alu,
    output logic            busy,
    output logic            done
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LDH   = 3'b001;
    localparam logic [2:0] OP_LDL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_SHL   = 3'b100;
    localparam logic [2:0] OP_ASR   = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_CLR   = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SH_W-1:0]   rem_q, rem_d;
    logic [2:0]        op_q, op_d;
    logic              fill_q, fill_d;
    logic [2*W-1:0]    acc_q, acc_d;
    logic              done_q, done_d;
    logic              accept;

    // One bit step of the combined 2W-bit register; the halves are never
    // treated separately here, so bits cross the W boundary naturally.
    function automatic logic [2*W-1:0] step(input logic [2:0] op,
                                            input logic fill,
                                            input logic [2*W-1:0] a);
        logic [2*W-1:0] r;
        r = a;
        case (op)
            OP_SHR:  r = {fill, a[2*W-1:1]};
            OP_SHL:  r = {a[2*W-2:0], fill};
            OP_ASR:  r = {a[2*W-1], a[2*W-1:1]};
            OP_ROR:  r = {a[0], a[2*W-1:1]};
            default: r = a;
        endcase
        return r;
    endfunction

    assign accept = cmd_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        op_d    = op_q;
        fill_d  = fill_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_NOP: done_d = 1'b1;
                        OP_LDH: begin
                            acc_d[2*W-1:W] = in_select ? bus_data : alu_data;
                            done_d         = 1'b1;
                        end
                        OP_LDL: begin
                            acc_d[W-1:0] = acc_q[2*W-1:W];
                            done_d       = 1'b1;
                        end
                        OP_CLR: begin
                            acc_d  = '0;
                            done_d = 1'b1;
                        end
                        default: begin
                            // Shifts: a zero amount completes like a single-cycle op.
                            if (cmd_amt == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = SHIFT;
                                rem_d   = cmd_amt;
                                op_d    = cmd_op;
                                fill_d  = fill_value;
                            end
                        end
                    endcase
                end else if (high_clr) begin
                    acc_d[2*W-1:W] = '0;
                end
            end
            SHIFT: begin
                acc_d = step(op_q, fill_q, acc_q);
                rem_d = rem_q - 1'b1;
                if (rem_q == SH_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            op_q    <= OP_NOP;
            fill_q  <= 1'b0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready         = (state_q == IDLE);
    assign busy              = (state_q == SHIFT);
    assign done              = done_q;
    assign acc_high_data2alu = acc_q[2*W-1:W];
    assign acc_low_data2alu  = acc_q[W-1:0];
    assign high_data2bus     = rd_en ? acc_q[2*W-1:W] : {W{1'bz}};
    assign low_data2bus      = rd_en ? acc_q[W-1:0]   : {W{1'bz}};

endmodule

// File: tb/tb_acc_seq_nbit.sv
module tb_acc_seq_nbit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       high_clr = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_amt = 4'd0;
    logic       fill_value = 1'b0;
    logic       in_select = 1'b0;
    logic [7:0] bus_data = 8'd0;
    logic [7:0] alu_data = 8'd0;
    logic       rd_en = 1'b1;
    wire  [7:0] high_data2bus;
    wire  [7:0] low_data2bus;
    logic [7:0] acc_high_data2alu;
    logic [7:0] acc_low_data2alu;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] model_acc = 16'h0000;

    acc_seq_nbit #(.W(8), .SH_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .high_clr(high_clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_amt(cmd_amt), .fill_value(fill_value), .in_select(in_select),
        .bus_data(bus_data), .alu_data(alu_data), .rd_en(rd_en),
        .high_data2bus(high_data2bus), .low_data2bus(low_data2bus),
        .acc_high_data2alu(acc_high_data2alu), .acc_low_data2alu(acc_low_data2alu),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: whole-command result from plain arithmetic on a 16-bit value.
    function automatic logic [15:0] ref_result(input logic [2:0] op, input int amt,
                                               input logic fill, input logic sel,
                                               input logic [7:0] b, input logic [7:0] a,
                                               input logic [15:0] cur);
        logic signed [15:0] s;
        logic [15:0] ones;
        ones = 16'hFFFF;
        s = cur;
        case (op)
            3'd1: return {(sel ? b : a), cur[7:0]};
            3'd2: return {cur[15:8], cur[15:8]};
            3'd3: return (cur >> amt) | (fill ? ~(ones >> amt) : 16'h0000);
            3'd4: return (cur << amt) | (fill ? ~(ones << amt) : 16'h0000);
            3'd5: return s >>> amt;
            3'd6: return (amt == 0) ? cur : ((cur >> amt) | (cur << (16 - amt)));
            3'd7: return 16'h0000;
            default: return cur;
        endcase
    endfunction

    // Issue one command at the current (post-edge) time, follow it through to its
    // done cycle, and return there so a following command lands back-to-back.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] amt, input logic fill,
                           input logic sel, input logic [7:0] b, input logic [7:0] a,
                           input bit poke, input string name);
        logic [15:0] exp;
        int exp_busy, n;
        exp = ref_result(op, int'(amt), fill, sel, b, a, model_acc);
        exp_busy = (op >= 3'd3 && op <= 3'd6 && amt != 0) ? int'(amt) : 0;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_before: got %b want 1", name, cmd_ready);
        end
        cmd_op = op; cmd_amt = amt; fill_value = fill; in_select = sel;
        bus_data = b; alu_data = a; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            vectors++;
            if (cmd_ready !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s busy_cycle%0d: ready=%b done=%b want 0 0", name, n, cmd_ready, done);
            end
            if (poke) begin
                // Anything offered while busy must be dropped.
                cmd_valid = $urandom_range(0, 1);
                cmd_op = 3'd7; cmd_amt = 4'($urandom); bus_data = 8'($urandom);
                alu_data = 8'($urandom); high_clr = $urandom_range(0, 1);
            end
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b0; high_clr = 1'b0;
        model_acc = exp;
        vectors++;
        if (n !== exp_busy) begin
            miscompares++;
            $display("FAIL %s busy_len: got %0d want %0d", name, n, exp_busy);
        end
        vectors++;
        if (done !== 1'b1 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_cycle: done=%b ready=%b want 1 1", name, done, cmd_ready);
        end
        vectors++;
        if ({acc_high_data2alu, acc_low_data2alu} !== exp) begin
            miscompares++;
            $display("FAIL %s result: got %h want %h", name, {acc_high_data2alu, acc_low_data2alu}, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_done: got %b want 0", done);
        end
    endtask

    task automatic set_acc(input logic [15:0] v);
        run_cmd(3'd1, 4'd0, 1'b0, 1'b1, v[7:0], 8'h00, 1'b0, "set_lo_h");
        run_cmd(3'd2, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "set_ldl");
        run_cmd(3'd1, 4'd0, 1'b0, 1'b0, 8'h00, v[15:8], 1'b0, "set_hi_h");
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rd_en = 1'b1;
        #12;
        vectors++;
        if ({high_data2bus, low_data2bus, acc_high_data2alu, acc_low_data2alu} !== 32'h0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: bus=%h%h alu=%h%h busy=%b done=%b want zeros",
                     high_data2bus, low_data2bus, acc_high_data2alu, acc_low_data2alu, busy, done);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        model_acc = 16'h0000;
        vectors++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b done=%b want 1 0", cmd_ready, done);
        end
    endtask

    task automatic test_loads();
        run_cmd(3'd1, 4'd0, 1'b0, 1'b1, 8'hA5, 8'h11, 1'b0, "load_high_bus");
        run_cmd(3'd2, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "load_low");
        run_cmd(3'd1, 4'd0, 1'b0, 1'b0, 8'h77, 8'h3C, 1'b0, "load_high_alu");
        vectors++;
        if ({acc_high_data2alu, acc_low_data2alu} !== 16'h3CA5) begin
            miscompares++;
            $display("FAIL loads_final: got %h want 3ca5", {acc_high_data2alu, acc_low_data2alu});
        end
        idle_cycle();
    endtask

    task automatic test_shr_fill();
        set_acc(16'hA53C);
        run_cmd(3'd3, 4'd4, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, "shr4_fill1");
        vectors++;
        if ({acc_high_data2alu, acc_low_data2alu} !== 16'hFA53) begin
            miscompares++;
            $display("FAIL shr_const: got %h want fa53", {acc_high_data2alu, acc_low_data2alu});
        end
        idle_cycle();
    endtask

    task automatic test_asr_ror();
        set_acc(16'h8001);
        run_cmd(3'd5, 4'd3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "asr3");
        vectors++;
        if ({acc_high_data2alu, acc_low_data2alu} !== 16'hF000) begin
            miscompares++;
            $display("FAIL asr_const: got %h want f000", {acc_high_data2alu, acc_low_data2alu});
        end
        set_acc(16'h0001);
        run_cmd(3'd6, 4'd1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "ror1");
        vectors++;
        if ({acc_high_data2alu, acc_low_data2alu} !== 16'h8000) begin
            miscompares++;
            $display("FAIL ror_const: got %h want 8000", {acc_high_data2alu, acc_low_data2alu});
        end
        idle_cycle();
    endtask

    task automatic test_shl_extremes();
        set_acc(16'h0001);
        run_cmd(3'd4, 4'd15, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "shl15");
        vectors++;
        if ({acc_high_data2alu, acc_low_data2alu} !== 16'h8000) begin
            miscompares++;
            $display("FAIL shl15_const: got %h want 8000", {acc_high_data2alu, acc_low_data2alu});
        end
        run_cmd(3'd4, 4'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "shl0");
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        set_acc(16'h1234);
        run_cmd(3'd6, 4'd5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "b2b_ror5");
        run_cmd(3'd3, 4'd2, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "b2b_shr2");
        run_cmd(3'd1, 4'd0, 1'b0, 1'b1, 8'hC3, 8'h00, 1'b0, "b2b_ldh");
        idle_cycle();
    endtask

    task automatic test_reset_midshift();
        set_acc(16'h5AC3);
        cmd_op = 3'd4; cmd_amt = 4'd8; fill_value = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        model_acc = 16'h0000;
        vectors++;
        if ({acc_high_data2alu, acc_low_data2alu} !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: acc=%h busy=%b done=%b want 0000 0 0",
                     {acc_high_data2alu, acc_low_data2alu}, busy, done);
        end
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || {acc_high_data2alu, acc_low_data2alu} !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_mid_after%0d: done=%b busy=%b acc=%h want 0 0 0000",
                         i, done, busy, {acc_high_data2alu, acc_low_data2alu});
            end
        end
    endtask

    task automatic test_bus();
        set_acc(16'h96E1);
        idle_cycle();
        rd_en = 1'b0;
        #1;
        // A released bus must not present the register contents.
        vectors++;
        if (high_data2bus === 8'h96 || low_data2bus === 8'hE1) begin
            miscompares++;
            $display("FAIL bus_released: got %h %h want zz zz", high_data2bus, low_data2bus);
        end
        vectors++;
        if (acc_high_data2alu !== 8'h96 || acc_low_data2alu !== 8'hE1) begin
            miscompares++;
            $display("FAIL alu_hold: got %h %h want 96 e1", acc_high_data2alu, acc_low_data2alu);
        end
        idle_cycle();
        rd_en = 1'b1;
        #1;
        vectors++;
        if (high_data2bus !== 8'h96 || low_data2bus !== 8'hE1) begin
            miscompares++;
            $display("FAIL bus_driven: got %h %h want 96 e1", high_data2bus, low_data2bus);
        end
    endtask

    task automatic test_high_clr();
        set_acc(16'h7B4D);
        idle_cycle();
        high_clr = 1'b1;
        @(posedge clk); #1;
        high_clr = 1'b0;
        model_acc[15:8] = 8'h00;
        vectors++;
        if ({acc_high_data2alu, acc_low_data2alu} !== 16'h004D || done !== 1'b0) begin
            miscompares++;
            $display("FAIL high_clr_idle: acc=%h done=%b want 004d 0",
                     {acc_high_data2alu, acc_low_data2alu}, done);
        end
        // Accepted command wins over a simultaneous high_clr.
        high_clr = 1'b1;
        run_cmd(3'd1, 4'd0, 1'b0, 1'b1, 8'hE7, 8'h00, 1'b0, "high_clr_vs_cmd");
        high_clr = 1'b0;
        idle_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            op = 3'($urandom);
            run_cmd(op, 4'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom), "random");
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_shr_fill();
        test_asr_ror();
        test_shl_extremes();
        test_back_to_back();
        test_reset_midshift();
        test_bus();
        test_high_clr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acc_seq_nbit.md
Name: acc_seq_nbit

Overview:
- Parametrised double-width accumulator: high and low halves, each W bits, concatenated as {high, low}.
- Successor to the fixed 4-bit accumulator.
- Adds a command handshake, multi-bit shifts sequenced one bit per clock, arithmetic shift, rotate, and a done pulse.
- Sits between the data bus and the ALU. Both halves drive the ALU directly and the bus through rd_en-gated tristate outputs.

Parameters:
- W, 8, width of each half; the accumulator is 2W bits.
- SH_W, 4, width of the shift amount; maximum shift is 2^SH_W-1 and must be ≤ 2W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- high_clr  in  1  synchronous clear of the high half.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command can be accepted.
- cmd_op  in  3  operation code.
- cmd_amt  in  SH_W  shift amount.
- fill_value  in  1  bit shifted into vacated positions (SHR/SHL).
- in_select  in  1  LOAD_HIGH source select: 1 = bus_data, 0 = alu_data.
- bus_data  in  W  data from the bus.
- alu_data  in  W  result from the ALU.
- rd_en  in  1  enables the bus output drivers.
- high_data2bus  out  W  high half when rd_en=1, else high-Z.
- low_data2bus  out  W  low half when rd_en=1, else high-Z.
- acc_high_data2alu  out  W  high half, always driven.
- acc_low_data2alu  out  W  low half, always driven.
- busy  out  1  multi-cycle shift in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - high=0, low=0, state=IDLE, remaining count=0, done=0, busy=0.
  - cmd_ready=1 after release.
  - Reset asserted mid-shift aborts the shift immediately; no done pulse is produced.
- Handshake:
  - cmd_ready = (state==IDLE).
  - A command is accepted on an edge where cmd_valid=1 and cmd_ready=1.
  - cmd_op, cmd_amt and fill_value are captured at acceptance.
  - cmd_valid while busy is ignored; it is not queued.
- cmd_op codes:
  - 000 NOP: no change.
  - 001 LOAD_HIGH: high <= in_select ? bus_data : alu_data.
  - 010 LOAD_LOW: low <= high (the value before this edge).
  - 011 SHR: logical right shift of {high,low}; fill from the MSB side with the captured fill_value.
  - 100 SHL: left shift of {high,low}; fill at the LSB with the captured fill_value.
  - 101 ASR: arithmetic right shift; each step fills with the current bit 2W-1.
  - 110 ROR: rotate right; bit 0 of low enters bit W-1 of high.
  - 111 CLR: high=0, low=0.
- Single-cycle ops (NOP, LOAD_*, CLR, and any shift with cmd_amt=0):
  - Register update happens on the acceptance edge.
  - done=1 for the following cycle.
  - busy stays 0.
- Shift with cmd_amt=k>0:
  - Acceptance edge: remaining<=k, state->SHIFT, registers unchanged.
  - Each edge in SHIFT performs exactly one bit step and decrements remaining.
  - The edge performing the k-th step sets state->IDLE and done<=1.
  - busy is high for exactly k cycles.
  - done is high in the first cycle after busy falls, and cmd_ready is already 1 in that cycle.
  - A new command may be accepted in that cycle (back-to-back).
- done: registered, high for exactly one cycle per completed command, never during busy.
- high_clr:
  - Honoured only in IDLE with no command accepted in the same cycle; it clears high only.
  - Ignored while busy or on an acceptance edge; the command takes precedence.
  - It does not produce done.
- Bus outputs:
  - rd_en is purely combinational; it has no effect on the registers.
  - The ALU outputs always reflect the registers.
- Shifts span the W boundary seamlessly: {high,low} is treated as one 2W-bit register.

Test Plan (W=8, SH_W=4):
- Reset:
  - Stimulus: reset_n=0 with rd_en=1, then release.
  - Response: both halves 0x00, busy=0, done=0, cmd_ready=1.
  - Stimulus: reset_n low mid-cycle with nonzero state.
  - Response: immediate clear, no clock needed.
- Loads:
  - Stimulus: LOAD_HIGH bus_data=0xA5 with in_select=1, then LOAD_LOW, then LOAD_HIGH alu_data=0x3C with in_select=0.
  - Response: final {high,low}=0x3CA5, with done pulsing once after each command.
- SHR with fill:
  - Stimulus: {high,low}=0xA53C, SHR amt=4, fill=1.
  - Response: busy for exactly 4 cycles, cmd_ready=0 throughout, cmd_valid pulses during busy ignored.
  - Response: result 0xFA53, done one cycle later.
- ASR, then ROR:
  - Stimulus: ASR amt=3 on 0x8001.
  - Response: 0xF000.
  - Stimulus: ROR amt=1 on 0x0001.
  - Response: 0x8000.
- SHL extremes:
  - Stimulus: SHL amt=15, fill=0 on 0x0001.
  - Response: 0x8000 after 15 busy cycles.
  - Stimulus: SHL amt=0.
  - Response: unchanged, busy never rises, done on the next cycle.
- Reset and bus-side checks:
  - Stimulus: reset_n pulsed low during cycle 2 of an 8-step shift.
  - Response: registers 0, busy=0, no done pulse.
  - Stimulus: rd_en=0.
  - Response: both bus outputs high-Z while the ALU outputs hold their values.
  - Stimulus: high_clr while idle.
  - Response: high=0x00 and low unchanged.
